// File: rtl/wisc_pipe_pkg.sv
// wisc_pipe_pkg: forwarding codes, hazard FSM states and tracker entry type shared by the hazard block
package wisc_pipe_pkg;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_EX  = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;
  typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_FLUSH} state_e;
  typedef struct packed {
    logic       valid;
    logic [2:0] dest;
    logic       is_load;
  } trk_t;
endpackage

// File: rtl/fwd_sel.sv
// fwd_sel: youngest-first match of one source register against the EX/MEM/WB tracker
module fwd_sel
  import wisc_pipe_pkg::*;
(
  input  trk_t       ex_i,
  input  trk_t       mem_i,
  input  trk_t       wb_i,
  input  logic [2:0] src_i,
  input  logic       used_i,
  output logic [1:0] fwd_o,
  output logic       ld_o
);
  logic hx, hm, hw;
  assign hx = used_i && ex_i.valid && ex_i.dest == src_i;
  assign hm = used_i && mem_i.valid && mem_i.dest == src_i;
  assign hw = used_i && wb_i.valid && wb_i.dest == src_i;
  // ld_o tells the caller whether the selected producer is a load
  always_comb begin
    fwd_o = hx ? FWD_EX : hm ? FWD_MEM : hw ? FWD_WB : FWD_RF;
    ld_o = hx ? ex_i.is_load : hm ? mem_i.is_load : hw && wb_i.is_load;
  end
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: forwarding selects and load-use/branch/exception pipeline control.
// Define HAZ_PERF_CNT_EN to add the saturating stall_cnt output.
module fwd_hazard_ctrl
  import wisc_pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [2:0] id_rs_addr,
  input  logic [2:0] id_rt_addr,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic       id_rs_early,
  input  logic [2:0] id_dest_addr,
  input  logic       id_writes,
  input  logic       id_is_load,
  input  logic       branch_or_jump,
  input  logic       exception,
  output logic [1:0] checker_fwd,
  output logic [1:0] storing_fwd,
  output logic       skip_rf_Rs,
  output logic       skip_rf_Rt,
  output logic       stall,
  output logic       flush_if,
  output logic       bubble_ex
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);
  trk_t ex_q, mem_q, wb_q, ex_d;
  state_e state_q, state_d;
  logic [1:0] rs_code, rt_code;
  logic rs_ld, rt_ld, rs_haz, rt_haz, haz, run, stall_w, flush_w, bub;
  fwd_sel u_rs (.ex_i(ex_q), .mem_i(mem_q), .wb_i(wb_q), .src_i(id_rs_addr), .used_i(id_rs_used), .fwd_o(rs_code), .ld_o(rs_ld));
  fwd_sel u_rt (.ex_i(ex_q), .mem_i(mem_q), .wb_i(wb_q), .src_i(id_rt_addr), .used_i(id_rt_used), .fwd_o(rt_code), .ld_o(rt_ld));
  // After a stall the EX slot is a bubble, so a MEM match on an early Rs means a load still in flight
  always_comb begin
    rs_haz = (rs_code == FWD_EX && (rs_ld || id_rs_early)) ||
             (state_q == ST_STALL && id_rs_early && rs_code == FWD_MEM && rs_ld);
    rt_haz = rt_code == FWD_EX && rt_ld;
    haz = rs_haz || rt_haz;
    run = state_q != ST_FLUSH;
    stall_w = run && haz && !exception;
    flush_w = !run || (!haz && !exception && branch_or_jump);
    bub = !run || haz || exception;
    state_d = !run ? ST_RUN : exception ? ST_FLUSH : haz ? ST_STALL : ST_RUN;
    ex_d = bub ? '0 : trk_t'({id_valid && id_writes, id_dest_addr, id_is_load});
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
      mem_q <= '0;
      wb_q <= '0;
      state_q <= ST_RUN;
    end else begin
      ex_q <= ex_d;
      mem_q <= ex_q;
      wb_q <= mem_q;
      state_q <= state_d;
    end
  end
  assign checker_fwd = (rst || (stall_w && rs_haz)) ? FWD_RF : rs_code;
  assign storing_fwd = (rst || (stall_w && rt_haz)) ? FWD_RF : rt_code;
  assign skip_rf_Rs = checker_fwd == FWD_WB;
  assign skip_rf_Rt = storing_fwd == FWD_WB;
  assign stall = !rst && stall_w;
  assign flush_if = !rst && flush_w;
  assign bubble_ex = !rst && bub;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else if (stall_w && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end
  assign stall_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed scenarios plus random traffic against an in-flight-instruction model
module tb_fwd_hazard_ctrl;
  logic clk, rst, id_valid, id_rs_used, id_rt_used, id_rs_early, id_writes, id_is_load, branch_or_jump, exception;
  logic [2:0] id_rs_addr, id_rt_addr, id_dest_addr;
  logic [1:0] checker_fwd, storing_fwd;
  logic skip_rf_Rs, skip_rf_Rt, stall, flush_if, bubble_ex;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cnt;
`endif
  int checks = 0, errors = 0;
  logic mv[3], ml[3];
  logic [2:0] md[3];
  logic m_stalled, m_flush;
  int m_cnt;
  logic e_stall, e_flush, e_bub;
  logic [1:0] e_crs, e_crt;

  fwd_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rs_early(id_rs_early), .id_dest_addr(id_dest_addr),
    .id_writes(id_writes), .id_is_load(id_is_load), .branch_or_jump(branch_or_jump), .exception(exception),
    .checker_fwd(checker_fwd), .storing_fwd(storing_fwd), .skip_rf_Rs(skip_rf_Rs), .skip_rf_Rt(skip_rf_Rt),
    .stall(stall), .flush_if(flush_if), .bubble_ex(bubble_ex)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Nearest older producer of src: age 0 = one ahead (EX), 1 = two ahead, 2 = three ahead
  function automatic logic [1:0] nearest(input logic [2:0] src, input logic used, output int age);
    age = -1;
    for (int k = 0; k < 3; k++)
      if (used && age < 0 && mv[k] && md[k] == src) age = k;
    case (age)
      0: return 2'b10;
      1: return 2'b01;
      2: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic mreset();
    for (int k = 0; k < 3; k++) begin
      mv[k] = 1'b0; ml[k] = 1'b0; md[k] = 3'd0;
    end
    m_stalled = 1'b0; m_flush = 1'b0; m_cnt = 0;
  endtask

  task automatic sample();
    int ars, art;
    logic rs_haz, rt_haz, haz;
    @(negedge clk);
    e_crs = nearest(id_rs_addr, id_rs_used, ars);
    e_crt = nearest(id_rt_addr, id_rt_used, art);
    rs_haz = (ars == 0 && (ml[0] || id_rs_early)) || (m_stalled && id_rs_early && ars == 1 && ml[1]);
    rt_haz = art == 0 && ml[0];
    haz = rs_haz || rt_haz;
    if (rst) begin
      e_stall = 0; e_flush = 0; e_bub = 0; e_crs = 0; e_crt = 0;
    end else if (m_flush) begin
      e_stall = 0; e_flush = 1; e_bub = 1;
    end else begin
      e_stall = haz && !exception;
      e_flush = !haz && !exception && branch_or_jump;
      e_bub = haz || exception;
      if (e_stall && rs_haz) e_crs = 2'b00;
      if (e_stall && rt_haz) e_crt = 2'b00;
    end
    chk("stall", 16'(stall), 16'(e_stall));
    chk("flush_if", 16'(flush_if), 16'(e_flush));
    chk("bubble_ex", 16'(bubble_ex), 16'(e_bub));
    chk("checker_fwd", 16'(checker_fwd), 16'(e_crs));
    chk("storing_fwd", 16'(storing_fwd), 16'(e_crt));
    chk("skip_rf_Rs", 16'(skip_rf_Rs), 16'(e_crs == 2'b11));
    chk("skip_rf_Rt", 16'(skip_rf_Rt), 16'(e_crt == 2'b11));
`ifdef HAZ_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, rst ? 16'd0 : 16'(m_cnt));
`endif
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) mreset();
    else begin
      if (e_stall && m_cnt < 65535) m_cnt++;
      for (int k = 2; k > 0; k--) begin
        mv[k] = mv[k-1]; md[k] = md[k-1]; ml[k] = ml[k-1];
      end
      mv[0] = !e_bub && id_valid && id_writes; md[0] = id_dest_addr; ml[0] = id_is_load;
      m_stalled = e_stall;
      m_flush = !m_flush && exception;
    end
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic instr(input logic v, input logic [2:0] rs, input logic rsu, input logic [2:0] rt,
                       input logic rtu, input logic early, input logic [2:0] dst, input logic wr, input logic ld);
    id_valid = v; id_rs_addr = rs; id_rs_used = rsu; id_rt_addr = rt; id_rt_used = rtu;
    id_rs_early = early; id_dest_addr = dst; id_writes = wr; id_is_load = ld;
    branch_or_jump = 1'b0; exception = 1'b0;
  endtask

  task automatic drain();
    instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
  endtask

  function automatic logic [2:0] rreg();
    return ($urandom_range(0, 7) == 0) ? 3'd7 : 3'($urandom_range(0, 3));
  endfunction

  initial begin
    rst = 1'b1;
    instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    mreset();
    step();
    rst = 1'b0;
    // Writer one ahead -> EX forward
    drain();
    instr(1, 0, 0, 0, 0, 0, 3, 1, 0); step();
    instr(1, 3, 1, 0, 0, 0, 0, 0, 0); sample();
    chk("d_ex_fwd", 16'(checker_fwd), 16'(2'b10));
    chk("d_ex_nostall", 16'(stall), 16'd0);
    advance();
    // Writer two ahead -> MEM forward
    drain();
    instr(1, 0, 0, 0, 0, 0, 3, 1, 0); step();
    instr(1, 0, 0, 0, 0, 0, 1, 0, 0); step();
    instr(1, 3, 1, 0, 0, 0, 0, 0, 0); sample();
    chk("d_mem_fwd", 16'(checker_fwd), 16'(2'b01));
    advance();
    // Writer three ahead -> WB bypass
    drain();
    instr(1, 0, 0, 0, 0, 0, 3, 1, 0); step();
    instr(1, 0, 0, 0, 0, 0, 1, 0, 0); step(); step();
    instr(1, 3, 1, 0, 0, 0, 0, 0, 0); sample();
    chk("d_wb_fwd", 16'(checker_fwd), 16'(2'b11));
    chk("d_wb_skip", 16'(skip_rf_Rs), 16'd1);
    advance();
    // Load-use on Rt: one stall, then MEM forward
    drain();
    instr(1, 0, 0, 0, 0, 0, 2, 1, 1); step();
    instr(1, 0, 0, 2, 1, 0, 0, 0, 0); sample();
    chk("d_ld_stall", 16'(stall), 16'd1);
    chk("d_ld_bubble", 16'(bubble_ex), 16'd1);
    chk("d_ld_forced", 16'(storing_fwd), 16'(2'b00));
    advance(); sample();
    chk("d_ld_fwd", 16'(storing_fwd), 16'(2'b01));
    chk("d_ld_release", 16'(stall), 16'd0);
    advance();
    // ALU result feeding an early-Rs branch: one stall, then MEM forward
    drain();
    instr(1, 0, 0, 0, 0, 0, 4, 1, 0); step();
    instr(1, 4, 1, 0, 0, 1, 0, 0, 0); branch_or_jump = 1'b1; sample();
    chk("d_br_stall", 16'(stall), 16'd1);
    chk("d_br_noflush", 16'(flush_if), 16'd0);
    advance(); sample();
    chk("d_br_fwd", 16'(checker_fwd), 16'(2'b01));
    chk("d_br_release", 16'(stall), 16'd0);
    chk("d_br_redirect", 16'(flush_if), 16'd1);
    advance();
    // R7 load feeding an early-Rs branch: two stalls, then WB bypass
    drain();
    instr(1, 0, 0, 0, 0, 0, 7, 1, 1); step();
    instr(1, 7, 1, 0, 0, 1, 0, 0, 0); sample();
    chk("d_r7_stall1", 16'(stall), 16'd1);
    advance(); sample();
    chk("d_r7_stall2", 16'(stall), 16'd1);
    advance(); sample();
    chk("d_r7_wb", 16'(checker_fwd), 16'(2'b11));
    chk("d_r7_release", 16'(stall), 16'd0);
    advance();
    // Exception beats a simultaneous load-use hazard
    drain();
    instr(1, 0, 0, 0, 0, 0, 5, 1, 1); step();
    instr(1, 0, 0, 5, 1, 0, 0, 0, 0); exception = 1'b1; sample();
    chk("d_exc_nostall", 16'(stall), 16'd0);
    advance();
    instr(0, 0, 0, 0, 0, 0, 0, 0, 0); sample();
    chk("d_exc_flush", 16'(flush_if), 16'd1);
    chk("d_exc_bubble", 16'(bubble_ex), 16'd1);
    chk("d_exc_stall", 16'(stall), 16'd0);
    advance(); sample();
    chk("d_exc_done", 16'(flush_if), 16'd0);
    advance();
    // Asynchronous reset in the middle of a stall
    drain();
    instr(1, 0, 0, 0, 0, 0, 6, 1, 1); step();
    instr(1, 6, 1, 6, 1, 0, 0, 0, 0); sample();
    chk("d_rst_pre", 16'(stall), 16'd1);
    #1 rst = 1'b1;
    #1;
    chk("d_rst_stall", 16'(stall), 16'd0);
    chk("d_rst_rs", 16'(checker_fwd), 16'd0);
    chk("d_rst_rt", 16'(storing_fwd), 16'd0);
    chk("d_rst_bubble", 16'(bubble_ex), 16'd0);
`ifdef HAZ_PERF_CNT_EN
    chk("d_rst_cnt", stall_cnt, 16'd0);
`endif
    advance();
    rst = 1'b0;
    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      instr($urandom_range(0, 7) != 0, rreg(), 1'($urandom_range(0, 1)), rreg(), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3) == 0, rreg(), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)));
      branch_or_jump = $urandom_range(0, 3) == 0;
      exception = $urandom_range(0, 15) == 0;
      rst = $urandom_range(0, 299) == 0;
      step();
      rst = 1'b0;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
